// File: rtl/mhd_err_accum.sv
// mhd_err_accum
// Accumulates Hamming-distance statistics between an approximate adder's output
// word and the exact adder's output word over a run of 2^NSAMP_LOG2 samples.
// Reports the total differing bits, the number of differing samples and,
// optionally, the largest unsigned absolute difference seen in the run.
//
// Optional feature: define MHD_MAXED_EN to build the absolute-difference
// datapath and max_ed tracking. Without it, max_ed is tied to zero and no
// subtractor or comparator is built. Timing is the same in both builds.

module mhd_err_accum #(
    parameter int W          = 6,
    parameter int NSAMP_LOG2 = 11,
    localparam int SW        = NSAMP_LOG2 + 4,
    localparam int CW        = NSAMP_LOG2 + 1
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          start,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [W-1:0]  approx_val,
    input  logic [W-1:0]  exact_val,
    output logic          busy,
    output logic          done,
    output logic [SW-1:0] hd_sum,
    output logic [CW-1:0] err_cnt,
    output logic [W-1:0]  max_ed
);

    typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

    state_t                  state;
    logic [NSAMP_LOG2-1:0]   samp_cnt;
    logic                    drain_cnt;
    logic                    accept;
    logic                    clear_acc;
    logic                    s1_valid;
    logic [W-1:0]            s1_xor;

    // Counts set bits of a word; W is at most 8, so four bits are enough.
    function automatic logic [3:0] popcount(input logic [W-1:0] v);
        logic [3:0] pc;
        pc = 4'd0;
        for (int i = 0; i < W; i++) begin
            pc = pc + 4'(v[i]);
        end
        return pc;
    endfunction

    // in_ready is a registered copy of "in RUN", so a handshake is just both high.
    assign accept    = in_ready & in_valid;
    assign clear_acc = start & ((state == IDLE) | (state == DONE));

    // Control FSM: all handshake/status outputs are registered here.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            samp_cnt  <= '0;
            drain_cnt <= 1'b0;
            in_ready  <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        state    <= RUN;
                        samp_cnt <= '0;
                        in_ready <= 1'b1;
                        busy     <= 1'b1;
                    end
                end
                RUN: begin
                    if (accept) begin
                        samp_cnt <= samp_cnt + NSAMP_LOG2'(1);
                        if (samp_cnt == '1) begin
                            state     <= DRAIN;
                            in_ready  <= 1'b0;
                            drain_cnt <= 1'b0;
                        end
                    end
                end
                DRAIN: begin
                    drain_cnt <= 1'b1;
                    if (drain_cnt) begin
                        state <= DONE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                    end
                end
                DONE: begin
                    if (start) begin
                        state    <= RUN;
                        samp_cnt <= '0;
                        in_ready <= 1'b1;
                        busy     <= 1'b1;
                        done     <= 1'b0;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    // Stage 1: capture the bitwise difference of each accepted pair.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid <= 1'b0;
            s1_xor   <= '0;
        end else begin
            s1_valid <= accept;
            if (accept) begin
                s1_xor <= approx_val ^ exact_val;
            end
        end
    end

    // Stage 2: fold the captured difference into the running totals.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hd_sum  <= '0;
            err_cnt <= '0;
        end else if (clear_acc) begin
            hd_sum  <= '0;
            err_cnt <= '0;
        end else if (s1_valid) begin
            hd_sum <= hd_sum + SW'(popcount(s1_xor));
            if (|s1_xor) begin
                err_cnt <= err_cnt + CW'(1);
            end
        end
    end

`ifdef MHD_MAXED_EN
    logic [W-1:0] s1_diff;

    // Stage 1 of the optional path: unsigned absolute difference of the pair.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_diff <= '0;
        end else if (accept) begin
            s1_diff <= (approx_val >= exact_val) ? (approx_val - exact_val)
                                                 : (exact_val - approx_val);
        end
    end

    // Stage 2 of the optional path: keep the largest difference of the run.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            max_ed <= '0;
        end else if (clear_acc) begin
            max_ed <= '0;
        end else if (s1_valid && (s1_diff > max_ed)) begin
            max_ed <= s1_diff;
        end
    end
`else
    assign max_ed = '0;
`endif

endmodule

// File: tb/tb_mhd_err_accum.sv
// tb_mhd_err_accum
// Directed bench for mhd_err_accum: a short-run instance (W=6, 4 samples) for
// handshake, timing, reset and restart behaviour, plus a full 2048-sample
// instance for the long-run totals. Honours MHD_MAXED_EN for max_ed expectations.

module tb_mhd_err_accum;

`ifdef MHD_MAXED_EN
    localparam bit MAXED = 1'b1;
`else
    localparam bit MAXED = 1'b0;
`endif

    logic       clk;
    logic       rst_n;
    logic       start;
    logic       in_valid;
    logic       in_ready;
    logic [5:0] approx_val;
    logic [5:0] exact_val;
    logic       busy;
    logic       done;
    logic [5:0] hd_sum;
    logic [2:0] err_cnt;
    logic [5:0] max_ed;

    logic        b_start;
    logic        b_valid;
    logic        b_ready;
    logic [5:0]  b_approx;
    logic [5:0]  b_exact;
    logic        b_busy;
    logic        b_done;
    logic [14:0] b_hd_sum;
    logic [11:0] b_err_cnt;
    logic [5:0]  b_max_ed;

    int vectors;
    int miscompares;

    mhd_err_accum #(.W(6), .NSAMP_LOG2(2)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .approx_val (approx_val),
        .exact_val  (exact_val),
        .busy       (busy),
        .done       (done),
        .hd_sum     (hd_sum),
        .err_cnt    (err_cnt),
        .max_ed     (max_ed)
    );

    mhd_err_accum #(.W(6), .NSAMP_LOG2(11)) dutBig (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (b_start),
        .in_valid   (b_valid),
        .in_ready   (b_ready),
        .approx_val (b_approx),
        .exact_val  (b_exact),
        .busy       (b_busy),
        .done       (b_done),
        .hd_sum     (b_hd_sum),
        .err_cnt    (b_err_cnt),
        .max_ed     (b_max_ed)
    );

    // Free-running clock shared by both instances.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Counts one comparison and reports it if the observed value is wrong.
    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        vectors++;
        if (obs !== expv) begin
            miscompares++;
            $display("[TB] FAIL %s: got %0d expected %0d", tag, obs, expv);
        end
    endtask

    // Pulses start for one cycle; returns #1 after the edge that sampled it.
    task automatic pulseStart();
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    // Offers one sample and holds it until it is accepted (bounded wait).
    task automatic applyStimulus(input logic [5:0] a, input logic [5:0] e);
        int waitCnt;
        waitCnt    = 0;
        approx_val = a;
        exact_val  = e;
        in_valid   = 1'b1;
        while (!in_ready && waitCnt < 20) begin
            @(posedge clk); #1;
            waitCnt++;
        end
        if (!in_ready) checkOutput("ready_timeout", 32'(in_ready), 32'd1);
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    // Called #1 after the final accept edge: checks drain timing and totals.
    task automatic finishRun(input string tag, input int expHd, input int expErr, input int expMax);
        checkOutput({tag, "_ready_drop"}, 32'(in_ready), 32'd0);
        checkOutput({tag, "_busy_drain"}, 32'(busy), 32'd1);
        checkOutput({tag, "_done_early0"}, 32'(done), 32'd0);
        @(posedge clk); #1;
        checkOutput({tag, "_done_early1"}, 32'(done), 32'd0);
        @(posedge clk); #1;
        checkOutput({tag, "_done"}, 32'(done), 32'd1);
        checkOutput({tag, "_busy_off"}, 32'(busy), 32'd0);
        checkOutput({tag, "_hd_sum"}, 32'(hd_sum), 32'(expHd));
        checkOutput({tag, "_err_cnt"}, 32'(err_cnt), 32'(expErr));
        checkOutput({tag, "_max_ed"}, 32'(max_ed), 32'(expMax));
    endtask

    bit stallPat [7] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};

    // Main directed sequence.
    initial begin
        int waitCnt;
        vectors     = 0;
        miscompares = 0;
        rst_n       = 1'b0;
        start       = 1'b0;
        in_valid    = 1'b0;
        approx_val  = '0;
        exact_val   = '0;
        b_start     = 1'b0;
        b_valid     = 1'b0;
        b_approx    = '0;
        b_exact     = '0;

        #3;
        checkOutput("rst_ready", 32'(in_ready), 32'd0);
        checkOutput("rst_busy", 32'(busy), 32'd0);
        checkOutput("rst_done", 32'(done), 32'd0);
        checkOutput("rst_hd", 32'(hd_sum), 32'd0);
        checkOutput("rst_err", 32'(err_cnt), 32'd0);
        checkOutput("rst_max", 32'(max_ed), 32'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        checkOutput("idle_ready", 32'(in_ready), 32'd0);

        $display("[TB] equal samples");
        pulseStart();
        checkOutput("run_ready", 32'(in_ready), 32'd1);
        checkOutput("run_busy", 32'(busy), 32'd1);
        for (int i = 0; i < 4; i++) applyStimulus(6'h15, 6'h15);
        finishRun("equal", 0, 0, 0);

        $display("[TB] mixed pairs");
        pulseStart();
        checkOutput("restart_done_fall", 32'(done), 32'd0);
        applyStimulus(6'h3F, 6'h00);
        applyStimulus(6'h01, 6'h00);
        applyStimulus(6'h10, 6'h10);
        applyStimulus(6'h00, 6'h20);
        finishRun("mixed", 8, 3, MAXED ? 63 : 0);

        $display("[TB] stalled in_valid");
        pulseStart();
        approx_val = 6'h05;
        exact_val  = 6'h04;
        for (int i = 0; i < 7; i++) begin
            in_valid = stallPat[i];
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        finishRun("stall", 4, 4, MAXED ? 1 : 0);

        $display("[TB] reset mid-run");
        pulseStart();
        applyStimulus(6'h0F, 6'h00);
        applyStimulus(6'h0F, 6'h00);
        @(posedge clk); #1;
        rst_n = 1'b0;
        #2;
        checkOutput("mid_rst_hd", 32'(hd_sum), 32'd0);
        checkOutput("mid_rst_err", 32'(err_cnt), 32'd0);
        checkOutput("mid_rst_max", 32'(max_ed), 32'd0);
        checkOutput("mid_rst_busy", 32'(busy), 32'd0);
        checkOutput("mid_rst_ready", 32'(in_ready), 32'd0);
        checkOutput("mid_rst_done", 32'(done), 32'd0);
        @(posedge clk); #1;
        rst_n    = 1'b1;
        in_valid = 1'b1;
        @(posedge clk); #1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        checkOutput("post_rst_idle_ready", 32'(in_ready), 32'd0);
        checkOutput("post_rst_idle_busy", 32'(busy), 32'd0);
        pulseStart();
        for (int i = 0; i < 4; i++) applyStimulus(6'h0F, 6'h00);
        finishRun("after_rst", 16, 4, MAXED ? 15 : 0);

        $display("[TB] start during RUN and DONE");
        pulseStart();
        applyStimulus(6'h03, 6'h00);
        applyStimulus(6'h03, 6'h00);
        pulseStart();
        checkOutput("run_start_busy", 32'(busy), 32'd1);
        checkOutput("run_start_ready", 32'(in_ready), 32'd1);
        applyStimulus(6'h03, 6'h00);
        applyStimulus(6'h03, 6'h00);
        finishRun("ignore_start", 8, 4, MAXED ? 3 : 0);
        pulseStart();
        checkOutput("done_start_done", 32'(done), 32'd0);
        checkOutput("done_start_hd", 32'(hd_sum), 32'd0);
        checkOutput("done_start_err", 32'(err_cnt), 32'd0);
        checkOutput("done_start_ready", 32'(in_ready), 32'd1);
        for (int i = 0; i < 4; i++) applyStimulus(6'h00, 6'h02);
        finishRun("rerun", 4, 4, MAXED ? 2 : 0);

        $display("[TB] full 2048-sample run");
        b_start = 1'b1;
        @(posedge clk); #1;
        b_start = 1'b0;
        checkOutput("big_ready", 32'(b_ready), 32'd1);
        b_valid = 1'b1;
        for (int i = 0; i < 2048; i++) begin
            b_approx = 6'(i);
            b_exact  = ~6'(i);
            @(posedge clk); #1;
        end
        b_valid = 1'b0;
        checkOutput("big_ready_drop", 32'(b_ready), 32'd0);
        waitCnt = 0;
        while (!b_done && waitCnt < 10) begin
            @(posedge clk); #1;
            waitCnt++;
        end
        checkOutput("big_done", 32'(b_done), 32'd1);
        checkOutput("big_done_latency", 32'(waitCnt), 32'd2);
        checkOutput("big_hd", 32'(b_hd_sum), 32'd12288);
        checkOutput("big_err", 32'(b_err_cnt), 32'd2048);
        checkOutput("big_max", 32'(b_max_ed), MAXED ? 32'd63 : 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/mhd_err_accum.md
MHD_ERR_ACCUM -- requirements
Module: mhd_err_accum

Interface
REQ-001 Parameter W, default 6, is the width of the compared output word (legal range 2..8).
REQ-002 Parameter NSAMP_LOG2, default 11, sets the run length to N = 2^NSAMP_LOG2 samples (default 2048 = exhaustive 11-bit input space).
REQ-003 Derived width SW = NSAMP_LOG2+4 (hd_sum); CW = NSAMP_LOG2+1 (err_cnt).
REQ-004 clk  input  1  sole clock, rising edge.
REQ-005 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-006 start  input  1  single-cycle request to begin a run.
REQ-007 in_valid  input  1  sample pair present on approx_val/exact_val.
REQ-008 in_ready  output  1  block accepts a sample this cycle.
REQ-009 approx_val  input  W  output word of the approximate adder under evaluation.
REQ-010 exact_val  input  W  output word of the exact adder for the same input vector.
REQ-011 busy  output  1  run in progress, including pipeline drain.
REQ-012 done  output  1  results valid; held until next start or reset.
REQ-013 hd_sum  output  SW  sum over the run of popcount(approx_val XOR exact_val).
REQ-014 err_cnt  output  CW  number of samples with approx_val != exact_val.
REQ-015 max_ed  output  W  maximum of |approx_val - exact_val| (unsigned) over the run.

Function
REQ-016 FSM states SHALL be IDLE, RUN, DRAIN, DONE.
REQ-017 IDLE: in_ready=0, busy=0, done=0; start -> RUN, clearing hd_sum, err_cnt, max_ed and the sample counter.
REQ-018 RUN: in_ready=1; a sample is accepted on a rising edge with in_valid=1 and in_ready=1; the counter increments per accepted sample.
REQ-019 On acceptance of sample N (counter wrap from N-1), in_ready SHALL drop in the next cycle and the FSM SHALL enter DRAIN.
REQ-020 Pipeline: stage 1 registers the XOR and absolute difference; stage 2 adds the popcount to hd_sum, increments err_cnt on nonzero XOR, and updates max_ed.
REQ-021 The final sample's contribution SHALL appear on the outputs 2 cycles after its acceptance edge; done SHALL rise in that same cycle, and the FSM SHALL enter DONE.
REQ-022 DRAIN lasts exactly 2 cycles; busy=1 throughout RUN and DRAIN.
REQ-023 DONE: done=1, busy=0, in_ready=0, results frozen; start -> RUN with results cleared (done falls the next cycle).
REQ-024 start in RUN or DRAIN SHALL be ignored.
REQ-025 in_valid=0 cycles in RUN stall the run without penalty; no timeout.
REQ-026 Accumulators are sized so no overflow occurs (max hd_sum = W*N < 2^SW); no saturation logic.
REQ-027 Intermediate hd_sum/err_cnt/max_ed values are visible during RUN but are only guaranteed meaningful while done=1.

Reset
REQ-028 rst_n low SHALL asynchronously force IDLE, with in_ready=0, busy=0, done=0, hd_sum=0, err_cnt=0, max_ed=0, the counter and pipeline valid bits cleared.
REQ-029 Reset mid-run SHALL discard all partial results; the next run requires a new start.

Configuration
REQ-030 Macro MHD_MAXED_EN defined: the absolute-difference datapath and max_ed tracking SHALL be built as in REQ-015/REQ-020.
REQ-031 MHD_MAXED_EN undefined: no subtractor or comparator is built, max_ed is tied to 0, and all other behaviour and timing SHALL be unchanged.

Verification (NSAMP_LOG2=2, W=6 unless stated)
REQ-032 4 samples with approx==exact, in_valid held 1 -> done 2 cycles after the 4th accept; hd_sum=0, err_cnt=0, max_ed=0.
REQ-033 Pairs (approx, exact) (0x3F,0x00), (0x01,0x00), (0x10,0x10), (0x00,0x20) -> hd_sum=8, err_cnt=3, max_ed=63 (max_ed=0 with MHD_MAXED_EN undefined).
REQ-034 in_valid toggled 1,0,0,1,1,0,1 -> only 4 samples accepted; done timing is measured from the last accept; in_ready=0 after the 4th accept.
REQ-035 rst_n pulsed low after 2 accepts -> all outputs 0 and FSM in IDLE; a new start plus 4 samples yields correct totals.
REQ-036 start asserted during RUN, then in DONE -> the first is ignored; the second clears the results and restarts the run.
REQ-037 NSAMP_LOG2=11, all 2048 pairs with approx XOR exact = 0x3F -> hd_sum=12288, err_cnt=2048.
